alu_control_sequencer: RTL and testbench

//  Command-driven control-word generator for the adder/accumulator datapath.
//  - Accepts opcode+operand commands over a valid/ready handshake.
//  - Drives operand onto the shared bus and sequences nLa/nLb/Ea/Eu/sub T-states.
//  - Returns accumulator reads and ALU flags over a response valid/ready handshake.
//  - Sits between the host-facing pins and the alu/accumulator_register pair, replacing raw control pins.

---
 rtl/alu_control_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_control_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: command-driven control-word sequencer for the adder/accumulator datapath.
// Optional one-entry command skid buffer enabled by defining ALU_SEQ_SKID_EN.
module alu_control_sequencer #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [OP_W-1:0]   i_cmd_op,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic [DATA_W-1:0] o_bus_out,
    output logic              o_bus_drv,
    input  logic [DATA_W-1:0] i_bus_in,
    output logic              o_nla,
    output logic              o_nlb,
    output logic              o_ea,
    output logic              o_eu,
    output logic              o_sub,
    input  logic              i_cf_in,
    input  logic              i_zf_in,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [1:0]        o_rsp_flags,
    output logic              o_cmd_err
);
    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4);
    typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_EXE, S_FLG, S_OUT, S_RSP} state_t;
    state_t r_state;
    logic r_is_sub;
    logic w_acc, w_have, w_free, w_disp;
    logic [OP_W-1:0] w_op;
    logic [DATA_W-1:0] w_dat;
    // w_free marks the edge at which the FSM would be in or return to IDLE
    assign w_acc  = i_cmd_valid & o_cmd_ready;
    assign w_free = (r_state == S_IDLE) | (r_state == S_LDA) | ((r_state == S_RSP) & i_rsp_ready);
    assign w_disp = w_free & w_have;
`ifdef ALU_SEQ_SKID_EN
    logic r_skid_full;
    logic [OP_W-1:0] r_skid_op;
    logic [DATA_W-1:0] r_skid_data;
    logic w_store;
    assign o_cmd_ready = !r_skid_full;
    assign w_have  = r_skid_full | w_acc;
    assign w_op    = r_skid_full ? r_skid_op : i_cmd_op;
    assign w_dat   = r_skid_full ? r_skid_data : i_cmd_data;
    assign w_store = w_acc & (r_skid_full | !w_disp);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_full <= 1'b0;
        end else begin
            r_skid_full <= (r_skid_full & !w_disp) | w_store;
            if (w_store) begin
                r_skid_op   <= i_cmd_op;
                r_skid_data <= i_cmd_data;
            end
        end
    end
`else
    assign o_cmd_ready = (r_state == S_IDLE);
    assign w_have = w_acc;
    assign w_op   = i_cmd_op;
    assign w_dat  = i_cmd_data;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_sub    <= 1'b0;
            o_bus_out   <= '0;
            o_bus_drv   <= 1'b0;
            o_nla       <= 1'b1;
            o_nlb       <= 1'b1;
            o_ea        <= 1'b0;
            o_eu        <= 1'b0;
            o_sub       <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_flags <= 2'b00;
            o_cmd_err   <= 1'b0;
        end else begin
            o_bus_out <= '0;
            o_bus_drv <= 1'b0;
            o_nla     <= 1'b1;
            o_nlb     <= 1'b1;
            o_ea      <= 1'b0;
            o_eu      <= 1'b0;
            o_sub     <= 1'b0;
            o_cmd_err <= 1'b0;
            case (r_state)
                S_LDA: r_state <= S_IDLE;
                S_LDB: begin
                    r_state <= S_EXE;
                    o_eu    <= 1'b1;
                    o_nla   <= 1'b0;
                    o_sub   <= r_is_sub;
                end
                S_EXE: r_state <= S_FLG;
                S_FLG: begin
                    r_state     <= S_RSP;
                    o_rsp_flags <= {i_zf_in, i_cf_in};
                    o_rsp_data  <= '0;
                    o_rsp_valid <= 1'b1;
                end
                S_OUT: begin
                    r_state     <= S_RSP;
                    o_rsp_data  <= i_bus_in;
                    o_rsp_valid <= 1'b1;
                end
                S_RSP: if (i_rsp_ready) begin
                    r_state     <= S_IDLE;
                    o_rsp_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // a dispatched command overrides the IDLE return and registers its first control word
            if (w_disp) begin
                r_is_sub <= (w_op == OP_SUB);
                case (w_op)
                    OP_NOP: r_state <= S_IDLE;
                    OP_LDA: begin
                        r_state   <= S_LDA;
                        o_bus_drv <= 1'b1;
                        o_bus_out <= w_dat;
                        o_nla     <= 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        r_state   <= S_LDB;
                        o_bus_drv <= 1'b1;
                        o_bus_out <= w_dat;
                        o_nlb     <= 1'b0;
                    end
                    OP_OUT: begin
                        r_state <= S_OUT;
                        o_ea    <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        o_cmd_err <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed and random checks of the control sequencer against
// a datapath model and an arithmetic accumulator reference.
module tb_alu_control_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic cmd_valid = 1'b0, cmd_ready, rsp_ready = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00, bus_out, bus_in, rsp_data;
    logic bus_drv, nla, nlb, ea, eu, sub, rsp_valid, cmd_err, cf_in, zf_in;
    logic [1:0] rsp_flags;
    int tests = 0, fails = 0;
    logic [7:0] env_a = 8'h00, env_b = 8'h00;
    logic env_cf = 1'b0, env_zf = 1'b0;
    logic [7:0] ref_a = 8'h00;
    logic [1:0] ref_flags = 2'b00;
    localparam logic [7:0] C_IDLE = 8'b01100000;
    localparam logic [7:0] C_LDA  = 8'b10100000;
    localparam logic [7:0] C_LDB  = 8'b11000000;
    localparam logic [7:0] C_OUT  = 8'b01110000;
    localparam logic [7:0] C_RSP  = 8'b01100010;
    localparam logic [7:0] C_ERR  = 8'b01100001;

    alu_control_sequencer dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op), .i_cmd_data(cmd_data),
        .o_bus_out(bus_out), .o_bus_drv(bus_drv), .i_bus_in(bus_in),
        .o_nla(nla), .o_nlb(nlb), .o_ea(ea), .o_eu(eu), .o_sub(sub),
        .i_cf_in(cf_in), .i_zf_in(zf_in),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rsp_flags(rsp_flags), .o_cmd_err(cmd_err)
    );

    // datapath model: A/B registers, ALU with flag register captured when the result is used
    function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [8:0] t;
        t = s ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
        return {t[7:0] == 8'h00, t[8], t[7:0]};
    endfunction
    logic [9:0] w_alu;
    assign w_alu  = alu_f(env_a, env_b, sub);
    assign bus_in = bus_drv ? bus_out : ea ? env_a : eu ? w_alu[7:0] : 8'h00;
    assign cf_in  = env_cf;
    assign zf_in  = env_zf;
    always @(posedge clk) begin
        if (!nla) env_a <= bus_in;
        if (!nlb) env_b <= bus_in;
        if (eu) {env_zf, env_cf} <= w_alu[9:8];
    end

    logic [15:0] w_obs;
    assign w_obs = {bus_drv, nla, nlb, ea, eu, sub, rsp_valid, cmd_err, bus_out};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        chk("one_bus_driver", 16'(int'(bus_drv) + int'(ea) + int'(eu) <= 1), 16'd1);
        chk("nla_nlb_excl", 16'(nla | nlb), 16'd1);
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 16'(n < 20), 16'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int hold, input logic [7:0] data);
        chk("rsp_on", w_obs, {C_RSP, 8'h00});
        chk("rsp_data", 16'(rsp_data), 16'(data));
        chk("rsp_flags", 16'(rsp_flags), 16'(ref_flags));
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_hold", w_obs, {C_RSP, 8'h00});
            chk("rsp_hold_data", 16'(rsp_data), 16'(data));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_clear", w_obs, {C_IDLE, 8'h00});
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] d, input int hold);
        int r;
        logic s;
        issue(op, d);
        case (op)
            3'd0: chk("nop", w_obs, {C_IDLE, 8'h00});
            3'd1: begin
                chk("lda_drive", w_obs, {C_LDA, d});
                ref_a = d;
                @(negedge clk);
                chk("lda_done", w_obs, {C_IDLE, 8'h00});
            end
            3'd2, 3'd3: begin
                s = (op == 3'd3);
                r = s ? int'(ref_a) - int'(d) : int'(ref_a) + int'(d);
                ref_flags = {(r & 255) == 0, s ? (ref_a >= d) : (r > 255)};
                ref_a = 8'(r);
                chk("ldb", w_obs, {C_LDB, d});
                @(negedge clk);
                chk("exe", w_obs, {5'b00101, s, 2'b00, 8'h00});
                @(negedge clk);
                chk("flg", w_obs, {C_IDLE, 8'h00});
                @(negedge clk);
                drain(hold, 8'h00);
            end
            3'd4: begin
                chk("out", w_obs, {C_OUT, 8'h00});
                @(negedge clk);
                drain(hold, ref_a);
            end
            default: begin
                chk("err_pulse", w_obs, {C_ERR, 8'h00});
                @(negedge clk);
                chk("err_clear", w_obs, {C_IDLE, 8'h00});
            end
        endcase
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, w_obs, {C_IDLE, 8'h00});
        chk("reset_rsp", {6'd0, rsp_flags, rsp_data}, 16'h0000);
        chk("reset_ready", 16'(cmd_ready), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset_during");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset_after");
        run(3'd1, 8'h25, 0);
        run(3'd1, 8'hF0, 0);
        run(3'd2, 8'h20, 0);
        chk("add_flags", 16'(rsp_flags), 16'h0001);
        run(3'd1, 8'h10, 0);
        run(3'd3, 8'h10, 0);
        chk("sub_zf", 16'(rsp_flags[1]), 16'd1);
        run(3'd1, 8'h5A, 0);
        run(3'd4, 8'h00, 5);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stray_ready", w_obs, {C_IDLE, 8'h00});
        rsp_ready = 1'b0;
        run(3'd6, 8'h00, 0);
        issue(3'd2, 8'h33);
        @(negedge clk);
        chk("pre_reset_exe", w_obs, {8'b00101000, 8'h00});
        rst = 1'b1;
        @(negedge clk);
        chk_reset("reset_mid_exe");
        rst = 1'b0;
        ref_flags = 2'b00;
        @(negedge clk);
        chk_reset("reset_mid_after");
        run(3'd1, 8'($urandom), 0);
        repeat (60) run(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)));
`ifdef ALU_SEQ_SKID_EN
        run(3'd1, 8'h40, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_data  = 8'h05;
        @(negedge clk);
        chk("skid_ldb", w_obs, {C_LDB, 8'h05});
        chk("skid_ready_busy", 16'(cmd_ready), 16'd1);
        cmd_op   = 3'd4;
        cmd_data = 8'h00;
        @(negedge clk);
        chk("skid_exe", w_obs, {8'b00101000, 8'h00});
        cmd_op   = 3'd1;
        cmd_data = 8'h77;
        chk("skid_stall", 16'(cmd_ready), 16'd0);
        @(negedge clk);
        chk("skid_stall2", 16'(cmd_ready), 16'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("skid_rsp", w_obs, {C_RSP, 8'h00});
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("skid_out_nobubble", w_obs, {C_OUT, 8'h00});
        @(negedge clk);
        chk("skid_out_rsp", w_obs, {C_RSP, 8'h00});
        chk("skid_out_data", 16'(rsp_data), 16'h0045);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("skid_idle", w_obs, {C_IDLE, 8'h00});
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
